// File: rtl/sdram_pro_aref.sv
// SDRAM auto-refresh generator: times the refresh interval, requests the bus,
// and issues PRECHARGE-all plus AREF_NUM AUTO REFRESH commands per grant.
module sdram_pro_aref #(
    parameter int CNT_REF  = 750,
    parameter int TRP_CLK  = 2,
    parameter int TRC_CLK  = 7,
    parameter int AREF_NUM = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic        aref_end,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank,
    output logic [11:0] aref_addr,
    output logic        aref_ovf
);

    // state      | meaning
    // AREF_IDLE  | waiting for a pending request to be granted
    // AREF_PCH   | PRECHARGE all banks
    // AREF_TRP   | NOPs for tRP after precharge
    // AREF_AR    | AUTO REFRESH command
    // AREF_TRFC  | NOPs for tRC after each auto refresh
    // AREF_END   | one-cycle completion pulse
    typedef enum logic [2:0] {
        AREF_IDLE,
        AREF_PCH,
        AREF_TRP,
        AREF_AR,
        AREF_TRFC,
        AREF_END
    } state_t;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCH  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int REF_W    = (CNT_REF > 1) ? $clog2(CNT_REF) : 1;

    state_t              state_q,   state_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic [1:0]          ar_cnt_q,  ar_cnt_d;
    logic [REF_W-1:0]    cnt_ref_q, cnt_ref_d;
    logic                req_q,     req_d;
    logic                ovf_q,     ovf_d;
    logic                wrap;
    logic                grant;

    assign wrap  = init_end && (cnt_ref_q == REF_W'(CNT_REF - 1));
    assign grant = (state_q == AREF_IDLE) && req_q && aref_en && init_end;

    always_comb begin
        cnt_ref_d = '0;
        if (init_end && !wrap) begin
            cnt_ref_d = cnt_ref_q + 1'b1;
        end
        // A wrap at the grant edge starts a fresh request rather than an overrun.
        req_d = wrap ? 1'b1 : (grant ? 1'b0 : req_q);
        ovf_d = ovf_q | (wrap & req_q & ~grant);
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        ar_cnt_d = ar_cnt_q;
        case (state_q)
            AREF_IDLE: begin
                if (grant) begin
                    state_d = AREF_PCH;
                end
            end
            AREF_PCH: begin
                state_d = AREF_TRP;
            end
            AREF_TRP: begin
                if (wait_q == WAIT_W'(TRP_CLK - 1)) begin
                    state_d = AREF_AR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            AREF_AR: begin
                state_d  = AREF_TRFC;
                ar_cnt_d = ar_cnt_q + 1'b1;
            end
            AREF_TRFC: begin
                if (wait_q == WAIT_W'(TRC_CLK - 1)) begin
                    state_d = (ar_cnt_q < 2'(AREF_NUM)) ? AREF_AR : AREF_END;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            AREF_END: begin
                state_d  = AREF_IDLE;
                ar_cnt_d = '0;
            end
            default: begin
                state_d  = AREF_IDLE;
                ar_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= AREF_IDLE;
            wait_q    <= '0;
            ar_cnt_q  <= '0;
            cnt_ref_q <= '0;
            req_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ar_cnt_q  <= ar_cnt_d;
            cnt_ref_q <= cnt_ref_d;
            req_q     <= req_d;
            ovf_q     <= ovf_d;
        end
    end

    assign aref_cmd  = (state_q == AREF_PCH) ? CMD_PCH :
                       (state_q == AREF_AR)  ? CMD_AREF : CMD_NOP;
    assign aref_bank = 2'b11;
    assign aref_addr = 12'hFFF;
    assign aref_end  = (state_q == AREF_END);
    assign aref_req  = req_q;
    assign aref_ovf  = ovf_q;

endmodule

// File: doc/sdram_pro_aref.md
# sdram_pro_aref

Auto-refresh generator for the SDRAM controller, the stage directly downstream of the initialisation sequencer. After `init_end` rises it times the refresh interval, raises a request to the controller arbiter, and once granted drives one precharge-all followed by `AREF_NUM` auto-refresh commands onto its own command/bank/address outputs. The arbiter multiplexes these onto the SDRAM pins in the same format the init sequencer uses.

## Interface
Parameters:
- `CNT_REF`, 750: refresh interval in `sys_clk` cycles (15 µs at 50 MHz; 4096 rows / 64 ms with margin).
- `TRP_CLK`, 2: NOP cycles after PRECHARGE.
- `TRC_CLK`, 7: NOP cycles after each AUTO REFRESH.
- `AREF_NUM`, 2: AUTO REFRESH commands per grant (1..3).

Ports:
- `sys_clk`  in  1  system clock, 50 MHz, all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `init_end`  in  1  init sequencer done; level, stays high after init.
- `aref_en`  in  1  arbiter grant; sampled only in AREF_IDLE with `aref_req` high.
- `aref_req`  out  1  refresh request to arbiter.
- `aref_end`  out  1  one-cycle pulse, refresh sequence finished.
- `aref_cmd`  out  4  {cs_n, ras_n, cas_n, we_n}.
- `aref_bank`  out  2  bank address.
- `aref_addr`  out  12  address bus.
- `aref_ovf`  out  1  sticky: an interval expired while a request was still pending.

## Operation
- Command encodings: NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001.
- Interval counter `cnt_ref`: held at 0 while `init_end`=0. Otherwise increments every cycle and wraps from `CNT_REF`-1 to 0. It is free-running and is not restarted by a grant.
- `aref_req` sets on the cycle `cnt_ref` wraps to 0. It clears on the cycle after `aref_en` is sampled high in AREF_IDLE.
- A wrap while `aref_req` is already high does not queue a second request. Instead it sets `aref_ovf`, which is cleared only by reset.
- FSM states: AREF_IDLE, AREF_PCH, AREF_TRP, AREF_AR, AREF_TRFC, AREF_END.
  - IDLE → PCH when `aref_req` & `aref_en` & `init_end`.
  - PCH → TRP after 1 cycle.
  - TRP → AR after `TRP_CLK` cycles.
  - AR → TRFC after 1 cycle; increments `ar_cnt`.
  - TRFC → AR after `TRC_CLK` cycles if `ar_cnt` < `AREF_NUM`, otherwise TRFC → END.
  - END → IDLE after 1 cycle; clears `ar_cnt`.
- Outputs are decoded combinationally from the registered state:
  - PCH: cmd PRECHARGE, bank 2'b11, addr 12'hFFF (A10=1, all banks).
  - AR: cmd AUTO REFRESH, bank 2'b11, addr 12'hFFF.
  - All other states: cmd NOP, bank 2'b11, addr 12'hFFF.
  - `aref_end` = 1 only in END.
- `aref_en` while `aref_req`=0, or outside IDLE, is ignored.
- The wait counter uses ceil(log2(max(`TRP_CLK`,`TRC_CLK`)+1)) bits. It resets to 0 on every state entry.

## Timing
- Reset values, applied on the first rising edge with `sys_rst`=1:
  - State IDLE, `cnt_ref`=0, wait counter 0, `ar_cnt`=0.
  - `aref_req`=0, `aref_ovf`=0.
  - `aref_cmd`=4'b0111, `aref_bank`=2'b11, `aref_addr`=12'hFFF, `aref_end`=0.
- Reset mid-sequence aborts immediately to the state above. No partial command is repeated.
- The first request appears `CNT_REF` cycles after the first cycle with `init_end`=1.
- Grant latency: `aref_en` sampled at edge N puts PRECHARGE on `aref_cmd` during cycle N+1. `aref_req` is low from N+1.
- Sequence length from PCH to END inclusive is 1 + `TRP_CLK` + `AREF_NUM`×(1+`TRC_CLK`) + 1. With defaults this is 20 cycles:
  - PRECHARGE at cycle 1.
  - AUTO REFRESH at cycles 4 and 12.
  - `aref_end` at cycle 20.
- A wrap coinciding with END, or with the grant cycle itself, sets a new `aref_req` (not `aref_ovf`), because the old request is already cleared at that edge.
- `init_end` falling mid-sequence does not abort the sequence. It zeroes `cnt_ref` and blocks new grants.

## Test plan
- **Reset/idle.** Hold `sys_rst`=1 for 5 cycles, `init_end`=0 for 2000 cycles → cmd 4'b0111 throughout; `aref_req`=0; `aref_ovf`=0.
- **First request.** Raise `init_end` at cycle T → `aref_req` rises at T+750 and stays high with `aref_en`=0.
- **Nominal sequence.** Grant `aref_en` for 1 cycle with `aref_req` high → PRECHARGE/12'hFFF at +1, AUTO REFRESH at +4 and +12, NOP elsewhere, `aref_end` pulse at +20, `aref_req` low from +1.
- **Overrun.** Never grant → `aref_ovf` sets at the second wrap (T+1500) and stays high; `aref_req` stays 1 with a single pending request.
- **Spurious grant / mid-sequence grant.** `aref_en`=1 with `aref_req`=0, and again during TRFC → no state change and no extra commands.
- **Reset mid-sequence.** Assert `sys_rst` during the first TRFC → next cycle state IDLE, cmd NOP, `aref_req`=0, `cnt_ref`=0. After release and with `init_end`=1, the next request appears 750 cycles later.
